// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: streams round keys 0..10 forward, or expands into a
// local buffer and streams them 10..0 for the inverse cipher.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  // Byte 0 of the table sits in the top bits, so entry a lives at offset 8*(255-a).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign s = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_key_expansion #(
  parameter int DATA_LEN   = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                decrypt,
  input  logic [DATA_LEN-1:0] cipher_key,
  output logic                busy,
  output logic                key_valid_out,
  output logic [3:0]          round_idx,
  output logic [DATA_LEN-1:0] round_key,
  output logic                done
);
  typedef enum logic [2:0] {S_IDLE, S_FWD_EMIT, S_EXPAND, S_REV_EMIT, S_DONE} state_t;

  state_t              state;
  logic [DATA_LEN-1:0] cur_key;
  logic [DATA_LEN-1:0] key_buf [NUM_ROUNDS+1];
  logic [7:0]          rcon;
  logic [3:0]          cnt;

  logic [3:0][7:0]     rot_b, sub_b;
  logic [31:0]         t, n0, n1, n2, n3;
  logic [DATA_LEN-1:0] next_key;
  logic [7:0]          rcon_nxt;

  assign rot_b = {cur_key[23:0], cur_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_b[g]), .s(sub_b[g]));
  end

  assign t        = sub_b ^ {rcon, 24'h0};
  assign n0       = cur_key[127:96] ^ t;
  assign n1       = cur_key[95:64]  ^ n0;
  assign n2       = cur_key[63:32]  ^ n1;
  assign n3       = cur_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};
  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      key_valid_out <= 1'b0;
      done          <= 1'b0;
      round_idx     <= '0;
      round_key     <= '0;
      cur_key       <= '0;
      rcon          <= 8'h01;
      cnt           <= '0;
    end else begin
      key_valid_out <= 1'b0;
      done          <= 1'b0;
      round_idx     <= '0;
      round_key     <= '0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          // busy is still high in the cycle after done, which keeps that start out
          if (start && !busy) begin
            busy       <= 1'b1;
            cur_key    <= cipher_key;
            key_buf[0] <= cipher_key;
            cnt        <= '0;
            rcon       <= 8'h01;
            state      <= decrypt ? S_EXPAND : S_FWD_EMIT;
          end
        end
        S_FWD_EMIT: begin
          key_valid_out <= 1'b1;
          round_idx     <= cnt;
          round_key     <= cur_key;
          cur_key       <= next_key;
          rcon          <= rcon_nxt;
          cnt           <= cnt + 4'd1;
          if (cnt == 4'(NUM_ROUNDS)) state <= S_DONE;
        end
        S_EXPAND: begin
          key_buf[cnt + 4'd1] <= next_key;
          cur_key             <= next_key;
          rcon                <= rcon_nxt;
          if (cnt == 4'(NUM_ROUNDS - 1)) begin
            cnt   <= 4'(NUM_ROUNDS);
            state <= S_REV_EMIT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_REV_EMIT: begin
          key_valid_out <= 1'b1;
          round_idx     <= cnt;
          round_key     <= key_buf[cnt];
          cnt           <= cnt - 4'd1;
          if (cnt == 4'd0) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: FIPS-197 vectors, random keys against a
// GF(2^8)-derived key-schedule model, start-while-busy and reset-abort cases.

module tb_aes_key_expansion;
  logic         clk = 1'b0;
  logic         reset, start, decrypt;
  logic [127:0] cipher_key;
  logic         busy, key_valid_out, done;
  logic [3:0]   round_idx;
  logic [127:0] round_key;

  int checks = 0, failures = 0;
  logic [7:0]   sb [256];
  logic [127:0] got_keys [11];

  aes_key_expansion #(.DATA_LEN(128), .NUM_ROUNDS(10)) dut (
    .clk(clk), .reset(reset), .start(start), .decrypt(decrypt),
    .cipher_key(cipher_key), .busy(busy), .key_valid_out(key_valid_out),
    .round_idx(round_idx), .round_key(round_key), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; inj >= 0 raises start (with a junk key) for the edge after observation k=inj.
  task automatic run_op(input logic [127:0] key, input logic dec, input int inj);
    int   n, base, exp_idx;
    logic seen_done, busy_ok, zero_ok;
    start = 1'b1; decrypt = dec; cipher_key = key;
    tick();
    start = 1'b0; cipher_key = ~key; decrypt = ~dec;
    chk("busy_after_start", 128'(busy), 128'd1);
    n = 0; base = dec ? 11 : 1; seen_done = 1'b0; busy_ok = 1'b1; zero_ok = 1'b1;
    for (int k = 1; k <= 30 && !seen_done; k++) begin
      tick();
      if (!busy) busy_ok = 1'b0;
      if (key_valid_out) begin
        exp_idx = dec ? 10 - n : n;
        chk("valid_cycle", 128'(k), 128'(base + n));
        chk("round_idx", 128'(round_idx), 128'(exp_idx));
        chk("round_key", round_key, model_rk(key, exp_idx));
        if (round_idx <= 4'd10) got_keys[round_idx] = round_key;
        n++;
      end else if (round_key !== 128'h0) begin
        zero_ok = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_cycle", 128'(k), 128'(base + 11));
        chk("valid_count", 128'(n), 128'd11);
      end
      start = (k == inj);
      if (k == inj) cipher_key = {$urandom, $urandom, $urandom, $urandom};
    end
    if (!seen_done) chk("done_timeout", 128'd0, 128'd1);
    chk("busy_during_op", 128'(busy_ok), 128'd1);
    chk("key_zero_when_invalid", 128'(zero_ok), 128'd1);
    tick();
    start = 1'b0;
    chk("busy_after_done", 128'(busy), 128'd0);
    chk("done_single_pulse", 128'(done), 128'd0);
    tick();
  endtask

  typedef struct {
    logic [127:0] key;
    logic         dec;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    vec_t vt [8];
    logic ok;
    vt[0] = '{FIPS_KEY, 1'b0, 0,  FIPS_KEY};
    vt[1] = '{FIPS_KEY, 1'b0, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vt[2] = '{FIPS_KEY, 1'b0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[3] = '{FIPS_KEY, 1'b1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[4] = '{FIPS_KEY, 1'b1, 0,  FIPS_KEY};
    vt[5] = '{128'h0,   1'b0, 1,  128'h62636363626363636263636362636363};
    vt[6] = '{128'h0,   1'b0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vt[7] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 10,
              128'h13111d7fe3944a17f307a78b4d2b30c5};

    build_sbox();
    reset = 1'b0; start = 1'b1; decrypt = 1'b0; cipher_key = FIPS_KEY;
    repeat (3) tick();
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_valid", 128'(key_valid_out), 128'd0);
    chk("reset_key", round_key, 128'h0);
    chk("reset_idx", 128'(round_idx), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    reset = 1'b1; start = 1'b0;
    tick();
    chk("idle_busy", 128'(busy), 128'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].key, vt[i].dec, -1);
      chk("vector", got_keys[vt[i].idx], vt[i].exp);
    end

    // start pulses during a run, and in the done cycle, must be ignored
    run_op(FIPS_KEY, 1'b0, 4);
    run_op(FIPS_KEY, 1'b0, 12);
    run_op(FIPS_KEY, 1'b1, 22);

    for (int i = 0; i < 12; i++)
      run_op({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), -1);

    // reset abort mid reverse emit, with start held during reset
    start = 1'b1; decrypt = 1'b1; cipher_key = FIPS_KEY;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b0; start = 1'b1;
    tick();
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_valid", 128'(key_valid_out), 128'd0);
    chk("abort_key", round_key, 128'h0);
    chk("abort_done", 128'(done), 128'd0);
    reset = 1'b1; start = 1'b0;
    ok = 1'b1;
    repeat (12) begin
      tick();
      if (busy || done || key_valid_out) ok = 1'b0;
    end
    chk("quiet_after_abort", 128'(ok), 128'd1);
    run_op(FIPS_KEY, 1'b1, -1);
    chk("post_reset_rk10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- AES-128 key-schedule generator. It produces the round-key stream that the round datapath's AddRoundKey stage consumes through its round_key / key_valid_in inputs.
- Encrypt mode streams round keys 0..10 forward, one per cycle.
- Decrypt mode expands the full schedule into an internal buffer, then streams round keys 10..0 in reverse for the inverse cipher.

Parameters:
- DATA_LEN, 128, key/round-key width; only 128 is supported.
- NUM_ROUNDS, 10, number of expanded rounds; round keys emitted = NUM_ROUNDS+1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- decrypt  input  1  sampled with start; 0 = forward order, 1 = reverse order.
- cipher_key  input  DATA_LEN  AES-128 key; sampled with start; word0 = [127:96].
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- key_valid_out  output  1  round_key / round_idx valid this cycle; drives key_valid_in of the round datapath.
- round_idx  output  4  round number (0..10) of the current round_key.
- round_key  output  DATA_LEN  round key; zero whenever key_valid_out = 0.
- done  output  1  one-cycle pulse after the last round key is emitted.

Behaviour:
- All outputs are registered. While reset = 0 at a clock edge: FSM to IDLE; busy, key_valid_out, done, round_idx, round_key all 0; buffer contents don't-care.
- FSM states: IDLE, FWD_EMIT, EXPAND, REV_EMIT, DONE.
- IDLE + start = 1 at edge T0:
  - Latch cipher_key as w[0..3].
  - Write buffer slot 0.
  - Round counter = 0, rcon = 8'h01.
  - Next state is FWD_EMIT if decrypt = 0, else EXPAND.
- FWD_EMIT:
  - At edge T0+1+r, r = 0..10: key_valid_out = 1, round_idx = r, round_key = round key r.
  - Round key 0 = cipher_key.
  - Each cycle computes the next round key from the current one.
  - After r = 10, go to DONE.
- EXPAND:
  - Edges T0+1..T0+10 compute round keys 1..10 into buffer slots 1..10.
  - key_valid_out = 0; busy = 1.
  - Then go to REV_EMIT.
- REV_EMIT:
  - Edges T0+11..T0+21 present buffer slots 10..0, with round_idx = 10..0.
  - Then go to DONE.
- DONE: done = 1, busy = 1, key_valid_out = 0 for one cycle (T0+12 forward, T0+22 reverse); then return to IDLE with busy = 0.
- Latency: first valid key at 1 cycle after start (forward) or 11 cycles (reverse). Valid keys are contiguous: no gaps, no backpressure.
- Expansion, per round, with prev = {p0,p1,p2,p3}:
  - t = SubWord(RotWord(p3)) ^ {rcon,24'h0}
  - n0 = p0^t; n1 = p1^n0; n2 = p2^n1; n3 = p3^n2
  - RotWord rotates left by one byte.
  - SubWord uses 4 combinational S-box lookups, one per byte.
  - rcon sequence: 01,02,04,08,10,20,40,80,1B,36. Update rule: xtime, i.e. shift left by 1, XOR 1B on carry.
- start while busy = 1 is ignored, including in the DONE cycle. cipher_key and decrypt changes during an operation have no effect.
- reset = 0 mid-operation: abort at that edge, all outputs to 0, no done pulse.
- start asserted in the same cycle that reset is low: ignored.

Test Plan:
- Forward, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, decrypt = 0 -> valid at T0+1..T0+11, round_idx 0..10:
  - round 0 = key
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done at T0+12.
- Reverse, same key, decrypt = 1 -> no valid on T0+1..T0+10:
  - T0+11: round_idx = 10, d014f9a8c9ee2589e13f0cc8b6630ca6
  - T0+21: round_idx = 0, 2b7e151628aed2a6abf7158809cf4f3c
  - done at T0+22.
- Zero key, forward -> round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Key 000102030405060708090a0b0c0d0e0f, forward -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Second start pulsed at T0+5 during the forward run with a different key -> stream unchanged, exactly 11 valids, one done.
- reset = 0 at T0+15 of a reverse run -> next cycle busy = 0, key_valid_out = 0, round_key = 0, no done. A fresh start after reset release produces the full correct sequence.
